// File: rtl/baud_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : baud_config_ctrl
//  Description : Arbitrates host and preset divisor-load requests, writes the
//                chosen 16-bit divisor to the baud generator as two byte
//                writes, then waits for the first baud tick (or a timeout)
//                to confirm the new rate is running.
//  Revision    : 1.0 - initial release
// ============================================================================
//
// Timing model (cycle = one clock period, outputs change just after posedge):
//   cycle N   : IDLE, grant ack pulses (decision registered on entry to N)
//   cycle N+1 : WR_LO strobe, busy rises
//   cycle N+2 : WR_HI strobe
//   cycle N+3 : WAIT_TICK entered, current_divisor shows the new value
// The grant is decided one edge ahead, from the requests present while the
// FSM is about to be IDLE, so that the ack itself can be a registered output
// that is visible during the IDLE grant cycle.

module baud_config_ctrl #(
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic [15:0] host_divisor,
  output logic        host_ack,
  input  logic        preset_req,
  input  logic [1:0]  preset_sel,
  output logic        preset_ack,
  output logic        baud_write_en,
  output logic        baud_write_location,
  output logic [7:0]  baud_generator_write_line,
  input  logic        baud_tick,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_timeout,
  output logic [15:0] current_divisor
);

  localparam int          CNT_W         = 17;
  localparam logic [16:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] RESET_DIVISOR = 16'd326;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_LO     = 2'd1,
    WR_HI     = 2'd2,
    WAIT_TICK = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] divisor;            // divisor latched in the grant cycle
  logic [15:0] divisor_nxt;
  logic [15:0] preset_divisor;
  logic [15:0] host_clamped;
  logic [16:0] wait_cnt;
  logic [7:0]  line_nxt;
  logic        last_grant_preset;  // 1 = preset was granted most recently
  logic        granting;           // current cycle is an IDLE grant cycle
  logic        grant_nxt;          // next cycle will be a grant cycle
  logic        host_wins;
  logic        cnt_last;

  // the ack registers mark the grant cycle, so they double as the grant flag
  assign granting     = (state == IDLE) && (host_ack || preset_ack);
  assign cnt_last     = (wait_cnt == CNT_LAST);
  assign host_clamped = (host_divisor == 16'd0) ? 16'd1 : host_divisor;

  // Preset table: divisors for 4800/9600/19200/38400 baud at 50 MHz
  always_comb begin
    preset_divisor = 16'd326;
    case (preset_sel)
      2'd0: preset_divisor = 16'd651;
      2'd1: preset_divisor = 16'd326;
      2'd2: preset_divisor = 16'd163;
      2'd3: preset_divisor = 16'd81;
      default: preset_divisor = 16'd326;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state, round-robin arbitration and divisor/byte selection
  always_comb begin
    state_nxt   = state;
    grant_nxt   = 1'b0;
    host_wins   = 1'b0;
    divisor_nxt = divisor;
    line_nxt    = 8'h00;

    case (state)
      IDLE:      if (granting) state_nxt = WR_LO;
      WR_LO:     state_nxt = WR_HI;
      WR_HI:     state_nxt = WAIT_TICK;
      WAIT_TICK: if (baud_tick || cnt_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    // On a tie the requester that was not served last wins
    host_wins = host_req && (!preset_req || last_grant_preset);
    grant_nxt = (state_nxt == IDLE) && (host_req || preset_req);

    if (granting) begin
      divisor_nxt = host_ack ? host_clamped : preset_divisor;
    end

    case (state_nxt)
      WR_LO:   line_nxt = divisor_nxt[7:0];
      WR_HI:   line_nxt = divisor_nxt[15:8];
      default: line_nxt = 8'h00;
    endcase
  end

  // Grant acks and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_ack          <= 1'b0;
      preset_ack        <= 1'b0;
      last_grant_preset <= 1'b1;
    end else begin
      host_ack   <= grant_nxt && host_wins;
      preset_ack <= grant_nxt && !host_wins;
      if (grant_nxt) begin
        last_grant_preset <= !host_wins;
      end
    end
  end

  // Divisor latch, generator write port and committed divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor                   <= RESET_DIVISOR;
      current_divisor           <= RESET_DIVISOR;
      baud_write_en             <= 1'b0;
      baud_write_location       <= 1'b0;
      baud_generator_write_line <= 8'h00;
      busy                      <= 1'b0;
    end else begin
      divisor                   <= divisor_nxt;
      baud_write_en             <= (state_nxt == WR_LO) || (state_nxt == WR_HI);
      baud_write_location       <= (state_nxt == WR_HI);
      baud_generator_write_line <= line_nxt;
      busy                      <= (state_nxt != IDLE);
      // commit once the high byte has been written
      if (state == WR_HI) begin
        current_divisor <= divisor;
      end
    end
  end

  // WAIT_TICK counter and completion pulses; a tick beats a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      cfg_done    <= 1'b0;
      cfg_timeout <= 1'b0;
    end else begin
      if ((state == WAIT_TICK) && (state_nxt == WAIT_TICK)) begin
        wait_cnt <= wait_cnt + 17'd1;
      end else begin
        wait_cnt <= '0;
      end
      cfg_done    <= (state == WAIT_TICK) && baud_tick;
      cfg_timeout <= (state == WAIT_TICK) && !baud_tick && cnt_last;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baud_config_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_config_ctrl
//  Description : Scoreboard bench for baud_config_ctrl. Stimulus pushes the
//                expected output events (kind, value, cycle gap from previous
//                event); a negedge monitor pops and compares each event.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_config_ctrl;

  localparam int EV_HACK = 0, EV_PACK = 1, EV_WLO = 2, EV_WHI = 3, EV_DONE = 4, EV_TOUT = 5;
  localparam int W_HACK = 0, W_PACK = 1, W_END = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0;
  logic [15:0] host_divisor = 16'h0000;
  logic        host_ack;
  logic        preset_req = 1'b0;
  logic [1:0]  preset_sel = 2'd0;
  logic        preset_ack;
  logic        baud_write_en;
  logic        baud_write_location;
  logic [7:0]  baud_generator_write_line;
  logic        baud_tick = 1'b0;
  logic        busy;
  logic        cfg_done;
  logic        cfg_timeout;
  logic [15:0] current_divisor;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  typedef struct {
    int          kind;
    logic [16:0] val;   // {busy, data}
    int          gap;   // cycles since previous event, -1 = don't care
  } ev_t;
  ev_t q[$];

  baud_config_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .host_req                  (host_req),
    .host_divisor              (host_divisor),
    .host_ack                  (host_ack),
    .preset_req                (preset_req),
    .preset_sel                (preset_sel),
    .preset_ack                (preset_ack),
    .baud_write_en             (baud_write_en),
    .baud_write_location       (baud_write_location),
    .baud_generator_write_line (baud_generator_write_line),
    .baud_tick                 (baud_tick),
    .busy                      (busy),
    .cfg_done                  (cfg_done),
    .cfg_timeout               (cfg_timeout),
    .current_divisor           (current_divisor)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      EV_HACK: return "host_ack";
      EV_PACK: return "preset_ack";
      EV_WLO:  return "write_lo";
      EV_WHI:  return "write_hi";
      EV_DONE: return "cfg_done";
      EV_TOUT: return "cfg_timeout";
      default: return "none";
    endcase
  endfunction

  function automatic void push(input int k, input logic [16:0] v, input int g);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.gap  = g;
    q.push_back(e);
  endfunction

  task automatic observe(input int kind, input logic [16:0] val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s val=%h at cycle %0d, required no event",
               kname(kind), val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val !== val || (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
        errors++;
        $display("FAIL event_%s: got kind=%s val=%h gap=%0d, required kind=%s val=%h gap=%0d",
                 kname(e.kind), kname(kind), val, cyc - last_cyc, kname(e.kind), e.val, e.gap);
      end
    end
    last_cyc = cyc;
  endtask

  // Monitor: fixed order per cycle (completion, acks, write)
  always @(negedge clk) begin
    cyc++;
    if (cfg_done)    observe(EV_DONE, {busy, current_divisor});
    if (cfg_timeout) observe(EV_TOUT, {busy, current_divisor});
    if (host_ack)    observe(EV_HACK, {busy, 16'h0000});
    if (preset_ack)  observe(EV_PACK, {busy, 16'h0000});
    if (baud_write_en) begin
      observe(baud_write_location ? EV_WHI : EV_WLO, {busy, 8'h00, baud_generator_write_line});
    end else begin
      checks++;
      if (baud_write_location !== 1'b0 || baud_generator_write_line !== 8'h00) begin
        errors++;
        $display("FAIL idle_write_port: got loc=%b line=%h, required loc=0 line=00",
                 baud_write_location, baud_generator_write_line);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int which, input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (which)
        W_HACK:  seen = host_ack;
        W_PACK:  seen = preset_ack;
        default: seen = cfg_done | cfg_timeout;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_%s: actual=no pulse within %0d cycles, required=pulse", name, bound);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cur_div"}, current_divisor, 326);
    chk({tag, "_acks"}, {host_ack, preset_ack}, 0);
    chk({tag, "_write"}, {baud_write_en, baud_write_location, baud_generator_write_line}, 0);
    chk({tag, "_pulses"}, {cfg_done, cfg_timeout}, 0);
  endtask

  // One load: grant at N, writes N+1/N+2, tick (if any) driven in cycle N+tick_at
  task automatic run_load(input bit is_host, input logic [15:0] arg,
                          input logic [15:0] exp_div, input int tick_at);
    bit exp_done;
    exp_done = (tick_at >= 3) && (tick_at <= 22);
    push(is_host ? EV_HACK : EV_PACK, 17'h0, -1);
    push(EV_WLO, {1'b1, 8'h00, exp_div[7:0]}, 1);
    push(EV_WHI, {1'b1, 8'h00, exp_div[15:8]}, 1);
    if (exp_done) push(EV_DONE, {1'b0, exp_div}, tick_at - 1);
    else          push(EV_TOUT, {1'b0, exp_div}, 21);
    if (is_host) begin
      host_req = 1'b1; host_divisor = arg;
    end else begin
      preset_req = 1'b1; preset_sel = arg[1:0];
    end
    wait_for(is_host ? W_HACK : W_PACK, 10, "grant");
    chk("busy_in_grant_cycle", busy, 0);
    @(posedge clk); #1;
    host_req = 1'b0; preset_req = 1'b0;
    host_divisor = 16'hFFFF; preset_sel = ~arg[1:0];
    @(negedge clk);
    chk("busy_after_grant", busy, 1);
    if (tick_at >= 2) begin
      repeat (tick_at - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
    wait_for(W_END, 40, "completion");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Both requesters from the first cycle: host, preset, host (timeouts)
    push(EV_HACK, 17'h0, -1);
    push(EV_WLO, {1'b1, 16'h0034}, 1);
    push(EV_WHI, {1'b1, 16'h0012}, 1);
    push(EV_TOUT, {1'b0, 16'h1234}, 21);
    push(EV_PACK, 17'h0, 0);
    push(EV_WLO, {1'b1, 16'h0046}, 1);
    push(EV_WHI, {1'b1, 16'h0001}, 1);
    push(EV_TOUT, {1'b0, 16'h0146}, 21);
    push(EV_HACK, 17'h0, 0);
    push(EV_WLO, {1'b1, 16'h0034}, 1);
    push(EV_WHI, {1'b1, 16'h0012}, 1);
    push(EV_TOUT, {1'b0, 16'h1234}, 21);
    host_req = 1'b1; host_divisor = 16'h1234;
    preset_req = 1'b1; preset_sel = 2'd1;
    wait_for(W_HACK, 10, "rr_host1");
    chk("rr_busy_at_grant", busy, 0);
    wait_for(W_PACK, 40, "rr_preset");
    wait_for(W_HACK, 40, "rr_host2");
    @(posedge clk); #1;
    host_req = 1'b0; preset_req = 1'b0;
    wait_for(W_END, 40, "rr_end");
    repeat (2) @(posedge clk); #1;

    // Directed single loads
    run_load(1'b0, 16'd2, 16'd163, 10);        // preset 19200, tick at N+10
    run_load(1'b1, 16'h0000, 16'h0001, 10);    // host zero clamps to 1
    run_load(1'b0, 16'd0, 16'd651, 3);         // tick in first WAIT_TICK cycle
    run_load(1'b0, 16'd3, 16'd81, 22);         // tick coincides with timeout
    run_load(1'b1, 16'hA55A, 16'hA55A, 2);     // tick during WR_HI is ignored

    // Request while busy and stray tick outside WAIT_TICK
    push(EV_HACK, 17'h0, -1);
    push(EV_WLO, {1'b1, 16'h00EF}, 1);
    push(EV_WHI, {1'b1, 16'h00BE}, 1);
    push(EV_DONE, {1'b0, 16'hBEEF}, 9);
    push(EV_PACK, 17'h0, 0);
    push(EV_WLO, {1'b1, 16'h0051}, 1);
    push(EV_WHI, {1'b1, 16'h0000}, 1);
    push(EV_TOUT, {1'b0, 16'h0051}, 21);
    host_req = 1'b1; host_divisor = 16'hBEEF;
    wait_for(W_HACK, 10, "busy_host");
    @(posedge clk); #1;
    host_req = 1'b0; preset_req = 1'b1; preset_sel = 2'd3; baud_tick = 1'b1;
    @(posedge clk); #1 baud_tick = 1'b0;
    repeat (8) @(posedge clk);
    #1 baud_tick = 1'b1;
    @(posedge clk); #1 baud_tick = 1'b0;
    wait_for(W_PACK, 5, "busy_preset");
    @(posedge clk); #1 preset_req = 1'b0;
    wait_for(W_END, 40, "busy_end");
    repeat (2) @(posedge clk); #1;

    // Reset during WR_LO, request still held afterwards
    push(EV_HACK, 17'h0, -1);
    push(EV_WLO, {1'b1, 16'h005A}, 1);
    host_req = 1'b1; host_divisor = 16'h5A5A;
    wait_for(W_HACK, 10, "rst_grant");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    push(EV_HACK, 17'h0, -1);
    push(EV_WLO, {1'b1, 16'h005A}, 1);
    push(EV_WHI, {1'b1, 16'h005A}, 1);
    push(EV_TOUT, {1'b0, 16'h5A5A}, 21);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_for(W_HACK, 10, "rst_regrant");
    @(posedge clk); #1 host_req = 1'b0;
    wait_for(W_END, 40, "rst_end");

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
